// File: rtl/mem_responder_pkg.sv
// Shared memory-interface package: bus widths and
// the RUN/STALL encoding used by the memory responder.
package mem_responder_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_st_e;

endpackage

// File: rtl/mem_resp_pipe.sv
// Read-response delay line: LAT stages of valid+data.
// Ports: i_clk, i_rst_n, i_valid/i_data in, o_valid/o_data out.
module mem_resp_pipe
  import mem_responder_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [MEM_DW-1:0] i_data,
  output logic              o_valid,
  output logic [MEM_DW-1:0] o_data
);

  logic [LAT-1:0]    vld;
  logic [MEM_DW-1:0] dat [LAT];

  // Data stages only load behind a valid, so the last
  // stage holds the most recent response between pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= i_valid;
      if (i_valid) dat[0] <= i_data;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

  assign o_valid = vld[LAT-1];
  assign o_data  = dat[LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: fixed-latency in-order reads, capacity
// limit, optional stall injection and sticky error flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 4,
  parameter int MAX_OUT     = 4,
  parameter int STALL_EVERY = 0,
  parameter int STALL_CYC   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [MEM_AW-1:0] i_mem_addr,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [MEM_DW-1:0] i_mem_wdata,
  output logic              o_mem_ready,
  output logic [MEM_DW-1:0] o_mem_rdata,
  output logic              o_mem_valid,
  output logic              o_err
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [MEM_DW-1:0] mem [MEM_WORDS];
  logic [IW-1:0]     idx;
  logic              ready_en;
  logic [CW-1:0]     count;
  stall_st_e         st, st_n;
  logic [15:0]       acc_cnt, acc_n;
  logic [3:0]        stl_cnt, stl_n;
  logic              acc, rd_acc, wr_acc;
  logic              unused_addr;

  assign idx = i_mem_addr[IW+1:2];
  assign unused_addr =
    ^{i_mem_addr[MEM_AW-1:IW+2], i_mem_addr[1:0]};

  // A retiring response frees its slot in the same cycle.
  assign o_mem_ready = ready_en && (st == ST_RUN) &&
    ((count < CW'(MAX_OUT)) || o_mem_valid);

  assign acc    = (i_mem_ren | i_mem_wen) & o_mem_ready;
  assign rd_acc = acc & i_mem_ren & ~i_mem_wen;
  assign wr_acc = acc & i_mem_wen;

  mem_resp_pipe #(.LAT(LATENCY)) u_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (rd_acc),
    .i_data  (mem[idx]),
    .o_valid (o_mem_valid),
    .o_data  (o_mem_rdata)
  );

  // Array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem[idx] <= i_mem_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_en <= 1'b0;
      count    <= '0;
      st       <= ST_RUN;
      acc_cnt  <= '0;
      stl_cnt  <= '0;
      o_err    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      st       <= st_n;
      acc_cnt  <= acc_n;
      stl_cnt  <= stl_n;
      if (rd_acc && !o_mem_valid)
        count <= count + CW'(1);
      else if (!rd_acc && o_mem_valid)
        count <= count - CW'(1);
      if (acc && i_mem_ren && i_mem_wen)
        o_err <= 1'b1;
    end
  end

  always_comb begin
    st_n  = st;
    acc_n = acc_cnt;
    stl_n = stl_cnt;
    unique case (st)
      ST_RUN: begin
        if (acc && (STALL_EVERY != 0)) begin
          if (acc_cnt == 16'(STALL_EVERY - 1)) begin
            acc_n = '0;
            stl_n = '0;
            st_n  = ST_STALL;
          end else begin
            acc_n = acc_cnt + 16'd1;
          end
        end
      end
      ST_STALL: begin
        if (stl_cnt == 4'(STALL_CYC - 1)) begin
          stl_n = '0;
          st_n  = ST_RUN;
        end else begin
          stl_n = stl_cnt + 4'd1;
        end
      end
      default: st_n = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench: three responder configurations on shared stimulus,
// each checked against a queue-based reference model.
module tb_mem_responder;

  localparam int N = 3;
  localparam int W = 64;
  localparam int LAT[N] = '{4, 4, 4};
  localparam int MO[N]  = '{4, 2, 4};
  localparam int SE[N]  = '{0, 0, 3};
  localparam int SC[N]  = '{2, 2, 2};

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] wdata = '0;
  logic        rdy [N];
  logic        vld [N];
  logic        err [N];
  logic [31:0] rdat [N];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mm [N][W];
  rsp_t        q [N][$];
  int          stall_left [N];
  int          accs [N];
  bit          started [N];
  logic        err_m [N];
  logic [31:0] last [N];
  bit          exp_v [N];
  bit          exp_r [N];
  bit          got_acc [N];

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_WORDS(W), .LATENCY(LAT[0]), .MAX_OUT(MO[0]),
    .STALL_EVERY(SE[0]), .STALL_CYC(SC[0])
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_addr(addr),
    .i_mem_ren(ren), .i_mem_wen(wen),
    .i_mem_wdata(wdata), .o_mem_ready(rdy[0]),
    .o_mem_rdata(rdat[0]), .o_mem_valid(vld[0]),
    .o_err(err[0])
  );

  mem_responder #(
    .MEM_WORDS(W), .LATENCY(LAT[1]), .MAX_OUT(MO[1]),
    .STALL_EVERY(SE[1]), .STALL_CYC(SC[1])
  ) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_addr(addr),
    .i_mem_ren(ren), .i_mem_wen(wen),
    .i_mem_wdata(wdata), .o_mem_ready(rdy[1]),
    .o_mem_rdata(rdat[1]), .o_mem_valid(vld[1]),
    .o_err(err[1])
  );

  mem_responder #(
    .MEM_WORDS(W), .LATENCY(LAT[2]), .MAX_OUT(MO[2]),
    .STALL_EVERY(SE[2]), .STALL_CYC(SC[2])
  ) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_addr(addr),
    .i_mem_ren(ren), .i_mem_wen(wen),
    .i_mem_wdata(wdata), .o_mem_ready(rdy[2]),
    .o_mem_rdata(rdat[2]), .o_mem_valid(vld[2]),
    .o_err(err[2])
  );

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] obs=%h exp=%h",
             tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      stall_left[k] = 0;
      accs[k] = 0;
      started[k] = 0;
      err_m[k] = 0;
      last[k] = '0;
    end
  endtask

  // Expected outputs for the current cycle, then compare.
  task automatic check_now();
    logic [31:0] ed;
    for (int k = 0; k < N; k++) begin
      exp_v[k] = (q[k].size() > 0) &&
                 (q[k][0].due == cyc);
      exp_r[k] = started[k] && (stall_left[k] == 0) &&
                 ((q[k].size() < MO[k]) || exp_v[k]);
      ed = exp_v[k] ? q[k][0].data : last[k];
      chk("ready", k, 32'(rdy[k]), 32'(exp_r[k]));
      chk("valid", k, 32'(vld[k]), 32'(exp_v[k]));
      chk("rdata", k, rdat[k], ed);
      chk("err",   k, 32'(err[k]), 32'(err_m[k]));
    end
  endtask

  task automatic model_edge();
    bit   a;
    int   ix;
    rsp_t t;
    ix = int'(addr[7:2]);
    for (int k = 0; k < N; k++) begin
      if (exp_v[k]) begin
        last[k] = q[k][0].data;
        void'(q[k].pop_front());
      end
      a = (ren | wen) && exp_r[k];
      got_acc[k] = got_acc[k] | a;
      if (stall_left[k] > 0) begin
        stall_left[k]--;
      end else if (a && SE[k] != 0) begin
        accs[k]++;
        if (accs[k] == SE[k]) begin
          accs[k] = 0;
          stall_left[k] = SC[k];
        end
      end
      if (a && ren && !wen) begin
        t.due = cyc + LAT[k];
        t.data = mm[k][ix];
        q[k].push_back(t);
      end
      if (a && wen) mm[k][ix] = wdata;
      if (a && ren && wen) err_m[k] = 1'b1;
      started[k] = 1'b1;
    end
    cyc++;
  endtask

  task automatic step(input logic r, input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    ren = r;
    wen = w;
    addr = a;
    wdata = d;
    @(negedge clk);
    check_now();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  // Repeat a request until every configuration took it.
  task automatic step_all(input logic r, input logic w,
                          input logic [31:0] a,
                          input logic [31:0] d);
    int guard;
    guard = 0;
    for (int k = 0; k < N; k++) got_acc[k] = 0;
    do begin
      step(r, w, a, d);
      guard++;
    end while (!(got_acc[0] && got_acc[1] && got_acc[2])
               && guard < 50);
    checks++;
    assert (guard < 50) else begin
      errors++;
      $error("FAIL accept_timeout obs=%0d exp<50", guard);
    end
  endtask

  task automatic do_reset();
    ren = 0;
    wen = 0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_ready", k, 32'(rdy[k]), 32'd0);
      chk("rst_valid", k, 32'(vld[k]), 32'd0);
      chk("rst_rdata", k, rdat[k], 32'd0);
      chk("rst_err",   k, 32'(err[k]), 32'd0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    model_reset();
    do_reset();

    for (int i = 0; i < W; i++)
      step_all(0, 1, 32'(i * 4), $urandom());

    step_all(0, 1, 32'h40, 32'hDEADBEEF);
    step_all(1, 0, 32'h40, '0);
    idle(6);

    for (int i = 0; i < 4; i++)
      step_all(0, 1, 32'(i * 4), 32'(i + 1));
    idle(6);
    for (int i = 0; i < 4; i++)
      step(1, 0, 32'(i * 4), '0);
    idle(8);

    step_all(1, 1, 32'h10, 32'h5A5A5A5A);
    idle(6);
    step_all(1, 0, 32'h10, '0);
    idle(6);

    step_all(0, 1, 32'h80, 32'hC0FFEE11);
    for (int i = 0; i < 3; i++)
      step(1, 0, 32'(i * 8), '0);
    do_reset();
    idle(8);
    step_all(1, 0, 32'h80, '0);
    idle(6);

    for (int i = 0; i < 30; i++)
      step(1, 0, $urandom(), '0);
    idle(6);

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      r = int'($urandom_range(0, 99));
      ra = $urandom();
      step(r < 50, r >= 45 && r < 80, ra, $urandom());
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
